cdm_seq_mul8x8: RTL and testbench



---
 rtl/cdm_seq_mul8x8_pkg.sv | 10 +
 rtl/cdm_seq_mul8x8_cd1.sv | 8 +
 rtl/cdm_seq_mul8x8.sv | 103 ++++++++++
 tb/tb_cdm_seq_mul8x8.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/cdm_seq_mul8x8_pkg.sv
// Shared widths and FSM encoding for the sequential 8x8 multiplier.
package cdm_pkg;
   localparam int OPA_W  = 8;
   localparam int OPB_W  = 8;
   localparam int NIB_W  = 4;
   localparam int CORE_W = 12;
   localparam int PROD_W = 16;

   typedef enum logic [1:0] {IDLE, LO, HI, DONE} cdm_seq_state_t;
endpackage

// File: rtl/cdm_seq_mul8x8_cd1.sv
// cd1: combinational 8x4 unsigned array multiplier core, 12-bit result.
module cd1 (
   input  logic [7:0]  a,
   input  logic [3:0]  b,
   output logic [11:0] r
);
   assign r = 12'(a) * 12'(b);
endmodule

// File: rtl/cdm_seq_mul8x8.sv
// Sequential 8x8 unsigned multiplier: two nibble passes through one cd1 core.
// Optional accumulator enabled by defining CDM_SEQ_ACC_EN.
module cdm_seq_mul8x8
   import cdm_pkg::*;
#(
   parameter int OUT_W = 16,
   parameter int ACC_W = 24
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [OPA_W-1:0] a_in,
   input  logic [OPB_W-1:0] b_in,
`ifdef CDM_SEQ_ACC_EN
   input  logic             acc_clr,
   output logic [ACC_W-1:0] result,
`else
   output logic [OUT_W-1:0] result,
`endif
   output logic             out_valid,
   input  logic             out_ready
);

   generate
      if (OUT_W != 2 * OPA_W) begin : g_bad_out_w
         $error("cdm_seq_mul8x8: OUT_W must be 16");
      end
      if (ACC_W < OUT_W) begin : g_bad_acc_w
         $error("cdm_seq_mul8x8: ACC_W must be >= OUT_W");
      end
   endgenerate

   cdm_seq_state_t      state_q, state_nxt;
   logic [OPA_W-1:0]    a_reg;
   logic [OPB_W-1:0]    b_reg;
   logic [CORE_W-1:0]   lo_reg;
   logic [NIB_W-1:0]    core_b;
   logic [CORE_W-1:0]   core_r;
   logic [PROD_W-1:0]   prod;
   logic                accept;
`ifdef CDM_SEQ_ACC_EN
   logic                clr_q;
`endif

   assign accept = in_valid && in_ready;
   assign core_b = (state_q == LO) ? b_reg[NIB_W-1:0] : b_reg[OPB_W-1:NIB_W];
   // High-nibble partial is weighted by 16; widths guarantee no overflow.
   assign prod   = PROD_W'(lo_reg) + (PROD_W'(core_r) << NIB_W);

   cd1 u_core (
      .a (a_reg),
      .b (core_b),
      .r (core_r)
   );

   always_comb begin
      state_nxt = state_q;
      case (state_q)
         IDLE:    if (accept) state_nxt = LO;
         LO:      state_nxt = HI;
         HI:      state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         a_reg     <= '0;
         b_reg     <= '0;
         lo_reg    <= '0;
         result    <= '0;
`ifdef CDM_SEQ_ACC_EN
         clr_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_nxt;
         in_ready  <= (state_nxt == IDLE);
         out_valid <= (state_nxt == DONE);
         if (accept) begin
            a_reg <= a_in;
            b_reg <= b_in;
`ifdef CDM_SEQ_ACC_EN
            clr_q <= acc_clr;
`endif
         end
         if (state_q == LO) lo_reg <= core_r;
         if (state_q == HI) begin
`ifdef CDM_SEQ_ACC_EN
            // result doubles as the accumulator; wraps at ACC_W bits
            result <= (clr_q ? '0 : result) + ACC_W'(prod);
`else
            result <= OUT_W'(prod);
`endif
         end
      end
   end

endmodule

// File: tb/tb_cdm_seq_mul8x8.sv
// Self-checking bench for cdm_seq_mul8x8 (default and CDM_SEQ_ACC_EN builds).
module tb_cdm_seq_mul8x8;
`ifdef CDM_SEQ_ACC_EN
   localparam int RW = 24;
`else
   localparam int RW = 16;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [7:0]    a_in = '0;
   logic [7:0]    b_in = '0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [RW-1:0] result;
`ifdef CDM_SEQ_ACC_EN
   logic          acc_clr = 1'b0;
`endif

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   logic [RW-1:0] m_acc = '0;

   cdm_seq_mul8x8 dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a_in      (a_in),
      .b_in      (b_in),
`ifdef CDM_SEQ_ACC_EN
      .acc_clr   (acc_clr),
`endif
      .result    (result),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: plain product, optionally summed into a wrapping accumulator.
   task automatic model_step(input logic [7:0] a, input logic [7:0] b, input bit clr,
                             output logic [RW-1:0] exp);
      int unsigned p;
      p = int'(a) * int'(b);
`ifdef CDM_SEQ_ACC_EN
      m_acc = (clr ? RW'(0) : m_acc) + RW'(p);
      exp = m_acc;
`else
      exp = RW'(p);
      if (clr) m_acc = '0;
`endif
   endtask

   // Drives one operation with out_ready already set; returns at the cycle
   // where out_valid is first seen (does not consume).
   task automatic start_op(input logic [7:0] a, input logic [7:0] b, input bit clr,
                           output int lat, output int acc_cyc);
      int w;
      w = 0;
      while (!in_ready && w < 20) begin tick(); w++; end
      checks++;
      if (!in_ready) begin errors++; $display("FAIL in_ready_timeout: got 0 expected 1"); end
      a_in = a; b_in = b; in_valid = 1'b1;
`ifdef CDM_SEQ_ACC_EN
      acc_clr = clr;
`else
      if (clr) w = 0;
`endif
      acc_cyc = cyc;
      tick();
      in_valid = 1'b0;
      a_in = $urandom; b_in = $urandom;
      lat = 1;
      while (!out_valid && lat < 20) begin tick(); lat++; end
      checks++;
      if (!out_valid) begin errors++; $display("FAIL out_valid_timeout: got 0 expected 1"); end
   endtask

   task automatic do_op(input logic [7:0] a, input logic [7:0] b, input bit clr,
                        input string nm, output int acc_cyc);
      logic [RW-1:0] exp;
      int lat;
      model_step(a, b, clr, exp);
      start_op(a, b, clr, lat, acc_cyc);
      checks++;
      if (result !== exp) begin
         errors++; $display("FAIL %s result: got %h expected %h", nm, result, exp);
      end
      checks++;
      if (lat != 3) begin errors++; $display("FAIL %s latency: got %0d expected 3", nm, lat); end
      tick();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s after_consume: got ov=%b ir=%b expected ov=0 ir=1", nm, out_valid, in_ready);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick(); tick();
      m_acc = '0;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== '0) begin
         errors++;
         $display("FAIL reset: got ir=%b ov=%b res=%h expected ir=1 ov=0 res=0", in_ready, out_valid, result);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      int c;
      out_ready = 1'b1;
      do_op(8'h12, 8'h34, 1'b1, "basic", c);
   endtask

   task automatic test_corners();
      int c;
      do_op(8'hFF, 8'hFF, 1'b1, "corner_ff_ff", c);
      do_op(8'h00, 8'hAB, 1'b1, "corner_00_ab", c);
      do_op(8'h01, 8'hFF, 1'b1, "corner_01_ff", c);
      do_op(8'hFF, 8'h10, 1'b1, "corner_ff_10", c);
   endtask

   task automatic test_backpressure();
      logic [RW-1:0] exp;
      int lat, c, ov_cnt;
      out_ready = 1'b0;
      model_step(8'hA5, 8'h3C, 1'b1, exp);
      start_op(8'hA5, 8'h3C, 1'b1, lat, c);
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1; a_in = 8'h77; b_in = 8'h99;
         checks++;
         if (result !== exp || in_ready !== 1'b0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL stall_%0d: got res=%h ir=%b ov=%b expected res=%h ir=0 ov=1",
                     i, result, in_ready, out_valid, exp);
         end
         tick();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      ov_cnt = 0;
      for (int i = 0; i < 4; i++) begin
         if (out_valid) ov_cnt++;
         tick();
      end
      checks++;
      if (ov_cnt != 0) begin errors++; $display("FAIL single_transfer: got %0d extra expected 0", ov_cnt); end
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_ignored_in: got ir=%b expected 1", in_ready); end
   endtask

   task automatic test_reset_midop();
      int c, ov_cnt;
      a_in = 8'h55; b_in = 8'h66; in_valid = 1'b1;
      while (!in_ready) tick();
      tick();
      in_valid = 1'b0;
      tick();                 // now in HI
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      m_acc = '0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== '0) begin
         errors++;
         $display("FAIL midop_reset: got ov=%b ir=%b res=%h expected ov=0 ir=1 res=0", out_valid, in_ready, result);
      end
      ov_cnt = 0;
      for (int i = 0; i < 4; i++) begin
         if (out_valid) ov_cnt++;
         tick();
      end
      checks++;
      if (ov_cnt != 0) begin errors++; $display("FAIL midop_no_pulse: got %0d expected 0", ov_cnt); end
      do_op(8'h0F, 8'h0F, 1'b0, "after_reset_0f", c);
   endtask

   task automatic test_back_to_back();
      int c0, c1;
      do_op(8'h11, 8'h22, 1'b1, "b2b_0", c0);
      for (int i = 1; i < 4; i++) begin
         do_op(8'(i * 37), 8'(i * 91), 1'b0, "b2b", c1);
         checks++;
         if (c1 - c0 != 4) begin errors++; $display("FAIL b2b_period: got %0d expected 4", c1 - c0); end
         c0 = c1;
      end
   endtask

   task automatic test_random();
      int c;
      for (int i = 0; i < 30; i++)
         do_op(8'($urandom), 8'($urandom), bit'($urandom_range(0, 3) == 0), "random", c);
   endtask

`ifdef CDM_SEQ_ACC_EN
   task automatic test_acc();
      int c;
      logic [RW-1:0] lit [4];
      lit[0] = 24'h000100; lit[1] = 24'h000106; lit[2] = 24'h000107; lit[3] = 24'h00FE01;
      do_op(8'h10, 8'h10, 1'b1, "acc0", c);
      checks++; if (result !== lit[0]) begin errors++; $display("FAIL acc0_lit: got %h expected %h", result, lit[0]); end
      do_op(8'h02, 8'h03, 1'b0, "acc1", c);
      checks++; if (result !== lit[1]) begin errors++; $display("FAIL acc1_lit: got %h expected %h", result, lit[1]); end
      do_op(8'h01, 8'h01, 1'b0, "acc2", c);
      checks++; if (result !== lit[2]) begin errors++; $display("FAIL acc2_lit: got %h expected %h", result, lit[2]); end
      do_op(8'hFF, 8'hFF, 1'b1, "acc3", c);
      checks++; if (result !== lit[3]) begin errors++; $display("FAIL acc3_lit: got %h expected %h", result, lit[3]); end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_corners();
      test_backpressure();
      test_reset_midop();
      test_back_to_back();
      test_random();
`ifdef CDM_SEQ_ACC_EN
      test_acc();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
